// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-request RAM bus unit with byte lanes, ack wait states, timeout and extended read data
module mem_bus_ctrl #(
  parameter int XLEN = 64,
  parameter int ADDR_W = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic [XLEN/8-1:0] bus_be,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  input  logic              ram_ack
);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic [1:0] kind_q, size_q;
  logic uns_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0] wdata_q, data_q;
  logic [CW-1:0] cnt;
  logic [1:0] eff_size;
  logic illegal, acc, store, sgn;
  logic [LB-1:0] off;
  logic [6:0] shamt;
  logic [XLEN-1:0] lane, up, ext;
  assign eff_size = req_kind == 2'b00 ? 2'b10 : req_size;
  assign illegal = req_kind == 2'b11 || (XLEN == 32 && eff_size == 2'b11) ||
                   (req_addr[2:0] & 3'((4'd1 << eff_size) - 4'd1)) != 3'd0;
  assign acc = state == ACCESS;
  assign store = kind_q == 2'b10;
  assign sgn = kind_q == 2'b01 && !uns_q;
  assign off = addr_q[LB-1:0];
  // push the selected lane to the top, then shift back arithmetically or logically to extend
  assign lane = bus_rdata >> {off, 3'b000};
  assign shamt = size_q == 2'b11 ? 7'd0 : 7'(XLEN - (8 << size_q));
  assign up = lane << shamt;
  assign ext = sgn ? XLEN'($signed(up) >>> shamt) : up >> shamt;
  assign req_ready = state == IDLE;
  assign ram_cs = acc;
  assign ram_we = acc && store;
  assign ram_oe = acc && !store;
  assign bus_addr = acc ? {addr_q[ADDR_W-1:LB], LB'(0)} : '0;
  assign bus_be = acc ? NB'(((16'd1 << (5'd1 << size_q)) - 16'd1) << off) : '0;
  assign bus_wdata = acc && store ? wdata_q << {off, 3'b000} : '0;
  assign rsp_valid = state == RESP;
  assign rsp_data = rsp_valid ? data_q : '0;
  assign rsp_err = rsp_valid && err_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      kind_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (req_valid) begin
            kind_q <= req_kind;
            size_q <= eff_size;
            uns_q <= req_unsigned;
            addr_q <= req_addr;
            wdata_q <= req_wdata;
            data_q <= '0;
            err_q <= illegal;
            cnt <= '0;
            state <= illegal ? RESP : ACCESS;
          end
        ACCESS:
          if (ram_ack) begin
            data_q <= store ? '0 : ext;
            err_q <= 1'b0;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(TIMEOUT - 1)) begin
              err_q <= 1'b1;
              state <= RESP;
            end
          end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed and random requests checked against an arithmetic model of the bus unit
module tb_mem_bus_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, req_unsigned = 1'b0;
  logic [1:0] req_kind = '0, req_size = '0;
  logic [63:0] req_addr = '0, req_wdata = '0, rsp_data, bus_addr, bus_wdata, bus_rdata = '0;
  logic rsp_valid, rsp_err, ram_cs, ram_we, ram_oe, ram_ack = 1'b0;
  logic [7:0] bus_be;
  int checks = 0, errors = 0;
  logic [63:0] last_data;
  logic last_err;

  mem_bus_ctrl #(.XLEN(64), .ADDR_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_be(bus_be), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_oe(ram_oe), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one request from the IDLE negedge to the IDLE negedge after the response;
  // waits = ack-low cycles before ack, waits >= TO means the RAM never answers
  task automatic run(input logic [1:0] kind, input logic [63:0] addr, input logic [1:0] size,
                     input logic uns, input logic [63:0] wdata, input int waits,
                     input logic [63:0] rdata);
    int sb, off, nacc;
    logic illegal, err, neg;
    logic [63:0] mask, lane, val, be, wd, ed;
    sb = kind == 2'b00 ? 4 : 1 << size;
    illegal = kind == 2'b11 || (addr % sb) != 0;
    off = int'(addr % 8);
    err = illegal || waits >= TO;
    nacc = illegal ? 0 : (waits >= TO ? TO : waits + 1);
    mask = sb == 8 ? '1 : (64'd1 << (8 * sb)) - 64'd1;
    lane = (rdata >> (8 * off)) & mask;
    neg = kind == 2'b01 && !uns && lane[8*sb-1];
    val = neg ? lane | ~mask : lane;
    ed = (err || kind == 2'b10) ? 64'd0 : val;
    be = (((64'd1 << sb) - 64'd1) << off) & 64'hFF;
    wd = kind == 2'b10 ? wdata << (8 * off) : 64'd0;
    chk("idle_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_kind = kind; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata; bus_rdata = rdata; ram_ack = 1'($urandom);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= nacc; c++) begin
      ram_ack = (c == waits + 1);
      bus_rdata = rdata;
      @(negedge clk);
      chk("acc_cs", ram_cs, 1'b1);
      chk("acc_oe", ram_oe, kind != 2'b10);
      chk("acc_we", ram_we, kind == 2'b10);
      chk("acc_addr", bus_addr, addr & ~64'h7);
      chk("acc_be", {56'd0, bus_be}, be);
      chk("acc_wdata", bus_wdata, wd);
      chk("acc_ready", req_ready, 1'b0);
      chk("acc_rsp", rsp_valid, 1'b0);
      @(posedge clk); #1;
    end
    ram_ack = 1'($urandom);
    bus_rdata = {$urandom, $urandom};
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_err", rsp_err, err);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_cs", ram_cs, 1'b0);
    chk("rsp_ready", req_ready, 1'b0);
    last_data = rsp_data;
    last_err = rsp_err;
    @(posedge clk); #1;
    ram_ack = 1'b0;
    @(negedge clk);
    chk("post_valid", rsp_valid, 1'b0);
    chk("post_data", rsp_data, 64'd0);
    chk("post_ready", req_ready, 1'b1);
  endtask

  initial begin
    logic [1:0] k, s;
    logic [63:0] a;
    #12;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_cs", ram_cs, 1'b0);
    chk("rst_rsp", rsp_valid, 1'b0);
    chk("rst_be", {56'd0, bus_be}, 64'd0);
    chk("rst_addr", bus_addr, 64'd0);
    chk("rst_data", rsp_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run(2'b01, 64'h1000, 2'b11, 1'b0, 64'd0, 0, 64'h8877665544332211);
    chk("plan_dbl", last_data, 64'h8877665544332211);
    run(2'b01, 64'h1003, 2'b00, 1'b0, 64'd0, 0, 64'h0000000080112233);
    chk("plan_lb", last_data, 64'hFFFFFFFFFFFFFF80);
    run(2'b01, 64'h1003, 2'b00, 1'b1, 64'd0, 1, 64'h0000000080112233);
    chk("plan_lbu", last_data, 64'h0000000000000080);
    run(2'b10, 64'h2006, 2'b01, 1'b0, 64'h000000000000ABCD, 2, 64'hDEADBEEFDEADBEEF);
    chk("plan_sh", last_data, 64'd0);
    run(2'b01, 64'h1002, 2'b10, 1'b0, 64'd0, 0, 64'h1122334455667788);
    chk("plan_mis", last_err, 1'b1);
    run(2'b01, 64'h3000, 2'b10, 1'b0, 64'd0, TO, 64'h1122334455667788);
    chk("plan_to", last_err, 1'b1);
    run(2'b01, 64'h3000, 2'b10, 1'b0, 64'd0, TO - 1, 64'h1122334455667788);
    chk("plan_late_ack", last_err, 1'b0);
    run(2'b00, 64'h104, 2'b00, 1'b0, 64'd0, 0, 64'h00A0009300000000);
    chk("plan_fetch", last_data, 64'h0000000000A00093);
    run(2'b11, 64'h4000, 2'b10, 1'b0, 64'd0, 0, 64'd0);
    chk("plan_kind3", last_err, 1'b1);
    req_valid = 1'b1; req_kind = 2'b00; req_addr = 64'h108; ram_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2;
    chk("abort_cs_before", ram_cs, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_cs", ram_cs, 1'b0);
    chk("abort_oe", ram_oe, 1'b0);
    chk("abort_rsp", rsp_valid, 1'b0);
    chk("abort_ready", req_ready, 1'b1);
    @(posedge clk); #3;
    reset = 1'b0;
    ram_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 1'b0);
      chk("abort_idle", req_ready, 1'b1);
    end
    ram_ack = 1'b0;
    for (int i = 0; i < 40; i++) begin
      k = 2'($urandom);
      s = 2'($urandom);
      a = {32'd0, $urandom} | 64'($urandom % 8);
      if ($urandom % 2 == 1) a = a & ~((64'd1 << s) - 64'd1);
      run(k, a, s, 1'($urandom), {$urandom, $urandom}, int'($urandom % 6), {$urandom, $urandom});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Sequential memory-bus interface unit for the multicycle core; replaces direct ram_cs/ram_we/ram_oe driving by the controller.
- Accepts one fetch, load or store request at a time through a valid/ready handshake.
- Runs the RAM access with an acknowledge-based wait-state and timeout mechanism.
- Returns aligned, sign- or zero-extended read data, or an error, as a one-cycle response pulse.
- Generalised in data width (XLEN) and access size (byte, half, word, double) with byte enables.

Parameters:
- XLEN, 64, datapath and bus data width; legal values 32 or 64.
- ADDR_W, 64, address width.
- TIMEOUT, 16, maximum ACCESS cycles without ram_ack before an error is reported; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_kind  in  2  00 fetch, 01 load, 10 store, 11 reserved (treated as error).
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double; ignored for fetch, which is always word.
- req_unsigned  in  1  1 selects zero-extension of load data.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  XLEN  extended read data; 0 for stores and errors.
- rsp_err  out  1  misaligned access, illegal size/kind, or timeout; valid with rsp_valid.
- bus_addr  out  ADDR_W  bus-word-aligned address (low log2(XLEN/8) bits forced to 0).
- bus_wdata  out  XLEN  lane-shifted store data.
- bus_rdata  in  XLEN  RAM read data.
- bus_be  out  XLEN/8  byte-lane enables.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_ack  in  1  RAM completes the access this cycle.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. While reset is high: state IDLE, timeout counter 0, all latched request fields 0, every output 0 except req_ready = 1.
- Reset mid-operation: ram_cs, ram_we, ram_oe and rsp_valid drop immediately. No response is ever produced for the aborted request.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1; bus outputs 0.
  - On a clock edge with req_valid = 1, latch kind, addr, size, unsigned and wdata.
  - Legality check: size bytes = 1 << size. The access is illegal if the address is not a multiple of the size bytes, if kind = 11, or if size = 11 when XLEN = 32.
  - Illegal access -> RESP with error flag set; no bus cycle occurs.
  - Legal access -> ACCESS; timeout counter cleared.
- ACCESS:
  - req_ready = 0; ram_cs = 1.
  - ram_oe = 1 for fetch and load; ram_we = 1 for store.
  - bus_addr = latched addr with the low lane bits cleared.
  - Lane offset = addr modulo XLEN/8. Little-endian byte order.
  - bus_be = ((1 << size bytes) - 1) << offset.
  - bus_wdata = wdata << (8 * offset); driven as 0 for reads.
  - Edge with ram_ack = 1: capture the read lane (bus_rdata >> 8*offset), truncate to size, sign- or zero-extend to XLEN (fetch always zero-extended), go to RESP with no error.
  - Edge with ram_ack = 0: counter increments. If the counter was already TIMEOUT-1, go to RESP with error.
  - ram_ack in the final allowed cycle wins over timeout.
- RESP:
  - rsp_valid = 1 for exactly one cycle, with rsp_data and rsp_err.
  - Next edge -> IDLE. req_ready = 0 during RESP.
- Latency, measured from the accepting edge:
  - Zero-wait RAM: rsp_valid is high in the second cycle after accept.
  - Each wait cycle adds 1.
  - Illegal access: rsp_valid is high in the first cycle after accept.
- ram_ack is ignored outside ACCESS.
- Minimum throughput: one access per 3 cycles.
- rsp_data holds 0 whenever rsp_valid = 0.

Test Plan:
- Double load at 0x1000, ram_ack high on the first ACCESS cycle, bus_rdata = 0x8877665544332211 -> bus_addr 0x1000, bus_be 0xFF, ram_oe = 1, ram_we = 0. rsp_valid is high 2 cycles after accept with rsp_data 0x8877665544332211 and rsp_err 0.
- Byte load at 0x1003, bus_rdata = 0x0000000080112233, signed -> rsp_data 0xFFFFFFFFFFFFFF80. Repeat with req_unsigned = 1 -> 0x0000000000000080. bus_be = 0x08 in both cases.
- Half store at 0x2006, req_wdata = 0x000000000000ABCD, 2 wait cycles -> bus_addr 0x2000, bus_be 0xC0, bus_wdata[63:48] = 0xABCD, ram_we = 1 for 3 cycles. rsp_data 0, rsp_err 0.
- Word load at 0x1002 (misaligned) -> ram_cs never asserted; rsp_valid and rsp_err high in the first cycle after accept; rsp_data 0.
- TIMEOUT = 4 with ram_ack held low -> ram_cs high for exactly 4 cycles, then rsp_err = 1. Repeat with ram_ack in the 4th cycle -> rsp_err = 0.
- Fetch at 0x104 with bus_rdata = 0x00A0009300000000 -> rsp_data 0x0000000000A00093. A second fetch with reset pulsed during ACCESS -> ram_cs drops asynchronously, no rsp_valid, and req_ready = 1 after release.
